// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder
// Full-speed USB packet transmitter. It accepts a request from the protocol
// controller and serialises SYNC, PID, an optional payload with CRC16, then
// EOP onto the D+/D- pads. Bit stuffing and NRZI encoding are applied on the way out.
//
// Ports
//   clk                 system clock
//   n_rst               asynchronous active-low reset
//   tx_packet[1:0]      request: 00 idle, 01 data, 10 ACK, 11 NACK (sampled only in IDLE)
//   buffer_occupancy    bytes held in the data buffer (latched at acceptance)
//   tx_packet_data      show-ahead head byte of the data buffer
//   get_tx_packet_data  one-cycle pop strobe to the data buffer
//   tx_status           one-cycle pulse when the packet, including EOP, is done
//   tx_transfer_active  high from acceptance through the DONE cycle
//   dplus_out           registered D+ drive
//   dminus_out          registered D- drive
//
// Data buffer handshake: tx_packet_data must be valid whenever the buffer is
// non-empty. get_tx_packet_data is high for exactly one clk cycle. In that
// cycle the head byte is consumed, and the buffer advances to the next byte
// on the following edge. No back-pressure exists: the controller guarantees
// occupancy for the latched byte count.
//
// CLKS_PER_BIT must be at least 2. MAX_PAYLOAD must be in 1..127.

module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 4,
  parameter int MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       tx_status,
  output logic       tx_transfer_active,
  output logic       dplus_out,
  output logic       dminus_out
);

  localparam int               DIV_W    = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [6:0]       MAX_N    = 7'(MAX_PAYLOAD);

  localparam logic [1:0] REQ_IDLE = 2'b00;
  localparam logic [1:0] REQ_DATA = 2'b01;
  localparam logic [1:0] REQ_ACK  = 2'b10;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NACK  = 8'h5A;

  // Reflected form of x^16+x^15+x^2+1, for an LSB-first shift register.
  localparam logic [15:0] CRC_POLY_REFL = 16'hA001;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_EOP_SE0,
    S_EOP_J,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic [3:0]       bit_cnt, bit_d;
  logic [2:0]       ones_cnt, ones_d;
  logic [15:0]      crc, crc_d;
  logic [7:0]       shreg, shreg_d;
  logic             loaded, loaded_d;
  logic [1:0]       kind, kind_d;
  logic [6:0]       byte_total, total_d;
  logic [6:0]       byte_idx, idx_d;
  logic             dplus_d, dminus_d;

  logic        serial;
  logic        launch;
  logic        need_load;
  logic [7:0]  cur_byte;
  logic        stuff;
  logic        tx_bit;
  logic [15:0] crc_upd;
  logic [6:0]  idx_next;

  // Bit-serial states share the stuffing, NRZI and shift logic.
  assign serial = (state == S_SYNC) || (state == S_PID) || (state == S_DATA) ||
                  (state == S_CRC_LO) || (state == S_CRC_HI);

  // A new line level is launched in the first cycle of every bit period.
  // The line register then changes on the edge that ends that cycle.
  assign launch = (div_cnt == '0) && (state != S_IDLE) && (state != S_DONE);

  // A payload byte comes straight from the buffer head at the first launch
  // after the previous byte ended. It is held in shreg for the remaining bits.
  assign need_load = (state == S_DATA) && !loaded;
  assign cur_byte  = need_load ? tx_packet_data : shreg;
  assign stuff     = (ones_cnt == 3'd6);
  assign tx_bit    = stuff ? 1'b0 : cur_byte[0];
  assign crc_upd   = (crc >> 1) ^ ((crc[0] ^ cur_byte[0]) ? CRC_POLY_REFL : 16'h0000);
  assign idx_next  = byte_idx + 7'd1;

  assign tx_status          = (state == S_DONE);
  assign tx_transfer_active = (state != S_IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      ones_cnt   <= '0;
      crc        <= '0;
      shreg      <= '0;
      loaded     <= 1'b0;
      kind       <= REQ_IDLE;
      byte_total <= '0;
      byte_idx   <= '0;
      dplus_out  <= 1'b1;
      dminus_out <= 1'b0;
    end else begin
      state      <= state_d;
      div_cnt    <= div_d;
      bit_cnt    <= bit_d;
      ones_cnt   <= ones_d;
      crc        <= crc_d;
      shreg      <= shreg_d;
      loaded     <= loaded_d;
      kind       <= kind_d;
      byte_total <= total_d;
      byte_idx   <= idx_d;
      dplus_out  <= dplus_d;
      dminus_out <= dminus_d;
    end
  end

  always_comb begin
    state_d            = state;
    div_d              = div_cnt;
    bit_d              = bit_cnt;
    ones_d             = ones_cnt;
    crc_d              = crc;
    shreg_d            = shreg;
    loaded_d           = loaded;
    kind_d             = kind;
    total_d            = byte_total;
    idx_d              = byte_idx;
    dplus_d            = dplus_out;
    dminus_d           = dminus_out;
    get_tx_packet_data = 1'b0;

    if ((state == S_IDLE) || (state == S_DONE)) begin
      div_d = '0;
    end else begin
      div_d = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        dplus_d  = 1'b1;
        dminus_d = 1'b0;
        if (tx_packet != REQ_IDLE) begin
          state_d  = S_SYNC;
          kind_d   = tx_packet;
          shreg_d  = SYNC_BYTE;
          bit_d    = '0;
          ones_d   = '0;
          crc_d    = 16'hFFFF;
          loaded_d = 1'b0;
          idx_d    = '0;
          if (tx_packet == REQ_DATA) begin
            total_d = (buffer_occupancy > MAX_N) ? MAX_N : buffer_occupancy;
          end else begin
            total_d = '0;
          end
        end
      end

      S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI: begin
        if (launch) begin
          // NRZI: a 0 toggles J<->K, a 1 holds the line.
          dplus_d  = tx_bit ? dplus_out  : ~dplus_out;
          dminus_d = tx_bit ? dminus_out : ~dminus_out;

          if (need_load) begin
            get_tx_packet_data = 1'b1;
            shreg_d            = tx_packet_data;
            loaded_d           = 1'b1;
          end

          if (stuff) begin
            // The inserted 0 costs a bit time without consuming a data bit.
            ones_d = '0;
            if ((state == S_CRC_HI) && bit_cnt[3]) begin
              state_d = S_EOP_SE0;
              bit_d   = '0;
            end
          end else begin
            ones_d  = cur_byte[0] ? ones_cnt + 3'd1 : 3'd0;
            shreg_d = {1'b0, cur_byte[7:1]};
            if (state == S_DATA) begin
              crc_d = crc_upd;
            end

            if (bit_cnt == 4'd7) begin
              bit_d    = '0;
              loaded_d = 1'b0;
              case (state)
                S_SYNC: begin
                  state_d = S_PID;
                  if (kind == REQ_DATA) begin
                    shreg_d = PID_DATA0;
                  end else if (kind == REQ_ACK) begin
                    shreg_d = PID_ACK;
                  end else begin
                    shreg_d = PID_NACK;
                  end
                end
                S_PID: begin
                  if (kind != REQ_DATA) begin
                    state_d = S_EOP_SE0;
                  end else if (byte_total == '0) begin
                    state_d = S_CRC_LO;
                    shreg_d = ~crc[7:0];
                  end else begin
                    state_d = S_DATA;
                  end
                end
                S_DATA: begin
                  idx_d = idx_next;
                  if (idx_next == byte_total) begin
                    state_d = S_CRC_LO;
                    // The final payload bit is folded in this same cycle.
                    shreg_d = ~crc_upd[7:0];
                  end
                end
                S_CRC_LO: begin
                  state_d = S_CRC_HI;
                  shreg_d = ~crc[15:8];
                end
                default: begin
                  // If the last CRC bit completes a run of six 1s, one stuffed 0
                  // is still owed. bit_cnt=8 parks here until the stuffed 0 is sent.
                  if (cur_byte[0] && (ones_cnt == 3'd5)) begin
                    bit_d = 4'd8;
                  end else begin
                    state_d = S_EOP_SE0;
                  end
                end
              endcase
            end else begin
              bit_d = bit_cnt + 4'd1;
            end
          end
        end
      end

      S_EOP_SE0: begin
        if (launch) begin
          dplus_d  = 1'b0;
          dminus_d = 1'b0;
          if (bit_cnt == 4'd1) begin
            state_d = S_EOP_J;
            bit_d   = '0;
          end else begin
            bit_d = bit_cnt + 4'd1;
          end
        end
      end

      S_EOP_J: begin
        // The first launch drives J. The second launch marks the end of the J bit time.
        if (launch) begin
          dplus_d  = 1'b1;
          dminus_d = 1'b0;
          if (bit_cnt == 4'd1) begin
            state_d = S_DONE;
            bit_d   = '0;
          end else begin
            bit_d = 4'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
